// File: rtl/transaction_sequencer_pkg.sv
// Shared definitions for the transaction sequencer: FSM state encodings,
// balance RAM addresses of both players and status codes.
package transaction_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RD_S  = 4'd1,
        WT_S  = 4'd2,
        CAP_S = 4'd3,
        RD_R  = 4'd4,
        WT_R  = 4'd5,
        CAP_R = 4'd6,
        CHECK = 4'd7,
        WR_R  = 4'd8,
        WR_S  = 4'd9,
        DONE  = 4'd10,
        HOLD  = 4'd11
    } state_t;

    localparam int P1_ADDR = 0;
    localparam int P2_ADDR = 1;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_BAD_KEY  = 2'b01,
        ST_NO_FUNDS = 2'b10,
        ST_OVERFLOW = 2'b11
    } status_t;

endpackage

// File: rtl/transaction_sequencer_tx_check.sv
// Combinational transfer check: key, funds, overflow, and the new balances.
// BALANCE_SAT_EN: the receiver saturates instead of rejecting on overflow.
module tx_check
    import transaction_sequencer_pkg::*;
#(
    parameter int BAL_W = 8,
    parameter int KEY_W = 4
) (
    input  logic [BAL_W-1:0] bal_send,
    input  logic [BAL_W-1:0] bal_recv,
    input  logic [BAL_W-1:0] amount,
    input  logic [KEY_W-1:0] key_in,
    input  logic [KEY_W-1:0] key_ref,
    output status_t          status,
    output logic [BAL_W-1:0] new_send,
    output logic [BAL_W-1:0] new_recv
);

    logic [BAL_W:0] sum;

    assign sum      = {1'b0, bal_recv} + {1'b0, amount};
    assign new_send = bal_send - amount;

`ifdef BALANCE_SAT_EN
    assign new_recv = sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
`else
    assign new_recv = sum[BAL_W-1:0];
`endif

    // Priority order matters: the first failing check names the reject.
    always_comb begin
        status = ST_OK;
        if (key_in != key_ref)
            status = ST_BAD_KEY;
        else if (amount > bal_send)
            status = ST_NO_FUNDS;
`ifndef BALANCE_SAT_EN
        else if (sum[BAL_W])
            status = ST_OVERFLOW;
`endif
    end

endmodule

// File: rtl/transaction_sequencer.sv
// One coin transfer between the P1/P2 balances in a 2-cycle-latency RAM.
// Build with BALANCE_SAT_EN to saturate the receiver instead of rejecting overflow.
module transaction_sequencer
    import transaction_sequencer_pkg::*;
#(
    parameter int BAL_W  = 8,
    parameter int KEY_W  = 4,
    parameter int ADDR_W = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              sender,
    input  logic [BAL_W-1:0]  amount,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [KEY_W-1:0]  key_ref,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BAL_W-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [BAL_W-1:0]  mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status
);

    state_t            state, state_next;
    logic              snd_q;
    logic [BAL_W-1:0]  amt_q, bal_s, bal_r;
    logic [KEY_W-1:0]  kin_q, kref_q;
    logic              accept, snd_sel;
    logic [ADDR_W-1:0] addr_s, addr_r;
    status_t           chk_status;
    logic [BAL_W-1:0]  new_send, new_recv;

    assign accept  = (state == IDLE) && start;
    // Outputs are registered from the next state, so the address must use the
    // sender value being latched on the accept edge.
    assign snd_sel = accept ? sender : snd_q;
    assign addr_s  = snd_sel ? ADDR_W'(P2_ADDR) : ADDR_W'(P1_ADDR);
    assign addr_r  = snd_sel ? ADDR_W'(P1_ADDR) : ADDR_W'(P2_ADDR);

    tx_check #(.BAL_W(BAL_W), .KEY_W(KEY_W)) u_check (
        .bal_send (bal_s),
        .bal_recv (bal_r),
        .amount   (amt_q),
        .key_in   (kin_q),
        .key_ref  (kref_q),
        .status   (chk_status),
        .new_send (new_send),
        .new_recv (new_recv)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_S;
            RD_S:    state_next = WT_S;
            WT_S:    state_next = CAP_S;
            CAP_S:   state_next = RD_R;
            RD_R:    state_next = WT_R;
            WT_R:    state_next = CAP_R;
            CAP_R:   state_next = CHECK;
            CHECK:   state_next = (chk_status == ST_OK) ? WR_R : DONE;
            WR_R:    state_next = WR_S;
            WR_S:    state_next = DONE;
            DONE:    state_next = HOLD;
            HOLD:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            snd_q     <= 1'b0;
            amt_q     <= '0;
            kin_q     <= '0;
            kref_q    <= '0;
            bal_s     <= '0;
            bal_r     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_OK;
        end else begin
            state <= state_next;
            if (accept) begin
                snd_q  <= sender;
                amt_q  <= amount;
                kin_q  <= key_in;
                kref_q <= key_ref;
            end
            if (state == CAP_S) bal_s <= mem_rdata;
            if (state == CAP_R) bal_r <= mem_rdata;

            case (state_next)
                RD_S, WT_S, CAP_S, WR_S:   mem_addr <= addr_s;
                RD_R, WT_R, CAP_R, WR_R:   mem_addr <= addr_r;
                default:                   mem_addr <= mem_addr;
            endcase
            mem_we    <= (state_next == WR_R) || (state_next == WR_S);
            mem_wdata <= (state_next == WR_R) ? new_recv :
                         (state_next == WR_S) ? new_send : '0;
            busy      <= !(state_next inside {IDLE, DONE, HOLD});
            done      <= (state_next == DONE);

            if (accept)
                status <= ST_OK;
            else if (state == CHECK)
                status <= chk_status;
        end
    end

endmodule

// File: tb/tb_transaction_sequencer.sv
// Directed self-checking bench for transaction_sequencer with a 2-cycle RAM model.
// Expectations follow BALANCE_SAT_EN when the bench is built with it.
module tb_transaction_sequencer;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       sender;
    logic [7:0] amount;
    logic [3:0] key_in, key_ref;
    logic [0:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy, done;
    logic [1:0] status;

    int n_checks = 0;
    int n_fail   = 0;

    transaction_sequencer dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .sender    (sender),
        .amount    (amount),
        .key_in    (key_in),
        .key_ref   (key_ref),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .status    (status)
    );

    always #5 clock = ~clock;

    // RAM model: read data appears two cycles after the address.
    logic [7:0] ram [2];
    logic [7:0] rd1;
    logic       load;
    logic [7:0] load_p1, load_p2;
    int         wr_total = 0;
    int         wdata_bad = 0;
    logic [0:0] wr_addr [2];
    logic [7:0] wr_data [2];

    always @(posedge clock) begin
        rd1       <= ram[mem_addr];
        mem_rdata <= rd1;
        if (load) begin
            ram[0] <= load_p1;
            ram[1] <= load_p2;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_we) begin
            wr_addr[wr_total % 2] <= mem_addr;
            wr_data[wr_total % 2] <= mem_wdata;
            wr_total <= wr_total + 1;
        end else if (mem_wdata != 8'd0) begin
            wdata_bad <= wdata_bad + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] p1, input logic [7:0] p2);
        @(negedge clock);
        load_p1 = p1;
        load_p2 = p2;
        load    = 1'b1;
        @(negedge clock);
        load    = 1'b0;
    endtask

    // Raise start before an edge, count cycles (cycle 1 follows the accept edge)
    // until done, then drop start.
    task automatic run_tx(input logic s, input logic [7:0] amt, input logic [3:0] ki,
                          input logic [3:0] kr, output int cyc, output int nwr);
        int base;
        base = wr_total;
        @(negedge clock);
        sender  = s;
        amount  = amt;
        key_in  = ki;
        key_ref = kr;
        start   = 1'b1;
        cyc     = 0;
        @(posedge clock);
        for (int k = 1; k <= 30; k++) begin
            #1;
            if (done) begin
                cyc = k;
                break;
            end
            @(posedge clock);
        end
        if (cyc == 0) $display("FAIL done_timeout: got none expected a done pulse");
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        nwr = wr_total - base;
    endtask

    int cyc, nwr, busy_seen;

    initial begin
        resetn  = 1'b0;
        start   = 1'b0;
        sender  = 1'b0;
        amount  = 8'd0;
        key_in  = 4'd0;
        key_ref = 4'd0;
        load    = 1'b0;
        load_p1 = 8'd0;
        load_p2 = 8'd0;
        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_status", status, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        resetn = 1'b1;

        // 1: P1 pays P2 30
        preload(8'd100, 8'd50);
        run_tx(1'b0, 8'd30, 4'd7, 4'd7, cyc, nwr);
        chk("t1_cycles", cyc, 10);
        chk("t1_status", status, 0);
        chk("t1_nwr", nwr, 2);
        chk("t1_wr0_addr", wr_addr[0], 1);
        chk("t1_wr0_data", wr_data[0], 80);
        chk("t1_wr1_addr", wr_addr[1], 0);
        chk("t1_wr1_data", wr_data[1], 70);
        chk("t1_busy_after", busy, 0);

        // 2: insufficient funds by one
        preload(8'd20, 8'd50);
        run_tx(1'b0, 8'd21, 4'd3, 4'd3, cyc, nwr);
        chk("t2_cycles", cyc, 8);
        chk("t2_status", status, 2);
        chk("t2_nwr", nwr, 0);
        chk("t2_p1", ram[0], 20);
        chk("t2_p2", ram[1], 50);

        // 3: bad key wins even with funds
        preload(8'd100, 8'd100);
        run_tx(1'b0, 8'd1, 4'd5, 4'd6, cyc, nwr);
        chk("t3_status", status, 1);
        chk("t3_nwr", nwr, 0);

        // 4: receiver overflow
        preload(8'd10, 8'd250);
        run_tx(1'b0, 8'd10, 4'd1, 4'd1, cyc, nwr);
`ifdef BALANCE_SAT_EN
        chk("t4_status", status, 0);
        chk("t4_nwr", nwr, 2);
        chk("t4_p1", ram[0], 0);
        chk("t4_p2", ram[1], 255);
`else
        chk("t4_status", status, 3);
        chk("t4_cycles", cyc, 8);
        chk("t4_nwr", nwr, 0);
        chk("t4_p2", ram[1], 250);
`endif

        // P2 pays P1; receiver lands exactly on 255, sender exactly drained
        preload(8'd245, 8'd10);
        run_tx(1'b1, 8'd10, 4'd9, 4'd9, cyc, nwr);
        chk("edge_status", status, 0);
        chk("edge_wr0_addr", wr_addr[0], 0);
        chk("edge_p1", ram[0], 255);
        chk("edge_p2", ram[1], 0);

        // amount 0: still two writes with unchanged values
        preload(8'd33, 8'd44);
        run_tx(1'b0, 8'd0, 4'd2, 4'd2, cyc, nwr);
        chk("zero_status", status, 0);
        chk("zero_nwr", nwr, 2);
        chk("zero_p1", ram[0], 33);
        chk("zero_p2", ram[1], 44);

        // 5: start held high does not re-trigger
        preload(8'd100, 8'd0);
        @(negedge clock);
        sender = 1'b0; amount = 8'd1; key_in = 4'd4; key_ref = 4'd4;
        start  = 1'b1;
        cyc = 0;
        for (int k = 0; k < 30 && cyc == 0; k++) begin
            @(negedge clock);
            if (done) cyc = 1;
        end
        chk("t5_first_done", cyc, 1);
        busy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (busy || done) busy_seen++;
        end
        chk("t5_no_retrigger", busy_seen, 0);
        chk("t5_p1_once", ram[0], 99);
        start = 1'b0;
        run_tx(1'b0, 8'd1, 4'd4, 4'd4, cyc, nwr);
        chk("t5_second_cycles", cyc, 10);
        chk("t5_p1_twice", ram[0], 98);

        // 6: reset during WT_R (cycle 5 after accept)
        preload(8'd60, 8'd60);
        @(negedge clock);
        sender = 1'b0; amount = 8'd5; key_in = 4'd1; key_ref = 4'd1;
        start  = 1'b1;
        @(posedge clock);
        repeat (4) @(posedge clock);
        @(negedge clock);
        resetn = 1'b0;
        start  = 1'b0;
        @(posedge clock);
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_status", status, 0);
        chk("t6_done", done, 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (15) @(negedge clock);
        chk("t6_idle_busy", busy, 0);
        chk("t6_p1", ram[0], 60);
        chk("t6_p2", ram[1], 60);

        chk("wdata_zero_when_idle", wdata_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
